// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; also serves MTHI/MTLO writes and MFHI/MFLO reads.
// Latency: start sampled at edge E -> HI/LO written and done pulsed after edge E+WIDTH+1.
// Backpressure: busy stalls ID/EX and IF/ID; start/mthi/mtlo while busy are dropped (start is accepted in FIN).
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             flush,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;

    // Latched operand magnitudes and op attributes
    logic [WIDTH-1:0]     r_opa;
    logic [WIDTH-1:0]     r_opb;
    logic                 r_is_div;
    logic                 r_neg_res;   // product / quotient must be negated
    logic                 r_neg_rem;   // remainder takes the dividend's sign
    logic                 r_dbz;

    // Iteration accumulator: mul = running {upper, multiplier/lower}, div = {remainder, quotient}
    logic [WIDTH-1:0]     r_acc_hi;
    logic [WIDTH-1:0]     r_acc_lo;

    // Architectural registers and pulses
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_dbz_pulse;

    // FSM decodes
    logic                 w_accept;
    logic                 w_step;
    logic                 w_finish;
    logic                 w_wr_hi;
    logic                 w_wr_lo;

    // Operand conditioning
    logic                 w_signed;
    logic                 w_rs_neg;
    logic                 w_rt_neg;
    logic [WIDTH-1:0]     w_rs_abs;
    logic [WIDTH-1:0]     w_rt_abs;

    // Iteration step
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic [WIDTH-1:0]     w_step_hi;
    logic [WIDTH-1:0]     w_step_lo;

    // Final sign correction
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    // State register; reset drops any in-flight op without a done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode; flush beats start, start beats mthi/mtlo
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        w_wr_hi     = 1'b0;
        w_wr_lo     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!flush) begin
                    if (start) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_wr_hi = mthi;
                        w_wr_lo = mtlo;
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = S_FIN;
                    end
                end
            end
            S_FIN: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_finish = 1'b1;
                    if (start) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Take magnitudes of the incoming operands; op[0]=0 selects signed ops
    always_comb begin
        w_signed = ~op[0];
        w_rs_neg = w_signed & rs_data[WIDTH-1];
        w_rt_neg = w_signed & rt_data[WIDTH-1];
        w_rs_abs = w_rs_neg ? -rs_data : rs_data;
        w_rt_abs = w_rt_neg ? -rt_data : rt_data;
    end

    // One shift-add (mul) or restoring shift-subtract (div) step
    always_comb begin
        w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opa} : '0);
        w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        if (r_is_div) begin
            if (!w_div_diff[WIDTH]) begin
                w_step_hi = w_div_diff[WIDTH-1:0];
                w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_step_hi = w_div_shift[WIDTH-1:0];
                w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_step_hi = w_mul_sum[WIDTH:1];
            w_step_lo = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero / overflow results for the FIN write
    always_comb begin
        w_prod     = {r_acc_hi, r_acc_lo};
        w_prod_fix = r_neg_res ? -w_prod : w_prod;
        if (!r_is_div) begin
            w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod_fix[WIDTH-1:0];
        end else if (r_dbz) begin
            // Rebuild the original dividend from its magnitude and sign
            w_res_hi = r_neg_rem ? -r_opa : r_opa;
            w_res_lo = '1;
        end else begin
            // Most-negative / -1 falls out naturally: quotient magnitude 2^(W-1), no negate
            w_res_hi = r_neg_rem ? -r_acc_hi : r_acc_hi;
            w_res_lo = r_neg_res ? -r_acc_lo : r_acc_lo;
        end
    end

    // Operand latch on accept, then iterate the accumulator while running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dbz     <= 1'b0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
        end else if (w_accept) begin
            r_cnt     <= CNT_MAX;
            r_opa     <= w_rs_abs;
            r_opb     <= w_rt_abs;
            r_is_div  <= op[1];
            r_neg_res <= w_rs_neg ^ w_rt_neg;
            r_neg_rem <= w_rs_neg;
            r_dbz     <= op[1] & (rt_data == '0);
            r_acc_hi  <= '0;
            r_acc_lo  <= op[1] ? w_rs_abs : w_rt_abs;
        end else if (w_step) begin
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

    // HI/LO update: whole-result write at FIN, otherwise direct MTHI/MTLO writes in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi        <= '0;
            r_lo        <= '0;
            r_done      <= 1'b0;
            r_dbz_pulse <= 1'b0;
        end else begin
            r_done      <= w_finish;
            r_dbz_pulse <= w_finish & r_is_div & r_dbz;
            if (w_finish) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else begin
                if (w_wr_hi) begin
                    r_hi <= rs_data;
                end
                if (w_wr_lo) begin
                    r_lo <= rs_data;
                end
            end
        end
    end

    assign hi_out      = r_hi;
    assign lo_out      = r_lo;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz_pulse;

endmodule
